ahb_lite_interconnect_n: RTL and testbench
==========================================

Name: ahb_lite_interconnect_n

Overview:
Parametrised AHB-lite single-master interconnect. It is the successor to the fixed six-slave bus used in the system block. It decodes the address phase into NUM_SLAVES one-hot selects, registers the data-phase owner, and multiplexes HRDATA/HREADY/HRESP back to the master. It adds a built-in default slave that returns a two-cycle ERROR for unmapped transfers, and propagates per-slave HRESP.

Parameters:
NUM_SLAVES, 6, number of slave ports (1..16)
DEC_HI, 31, MSB of the HADDR decode field
DEC_LO, 24, LSB of the HADDR decode field (field width DW = DEC_HI-DEC_LO+1, max 8)
SLV_TAGS, {8'h60,8'h50,8'h48,8'h40,8'h20,8'h00}, packed NUM_SLAVES*8; slave i matches when HADDR[DEC_HI:DEC_LO] == SLV_TAGS[i*8 +: DW]
TIMEOUT_CYCLES, 16, wait-state limit; used only with the optional feature

Ports:
HCLK  in  1  bus clock; all state on rising edge
HRESET  in  1  reset; one clock; reset is asynchronous and active-high
HADDR  in  32  master address
HTRANS  in  2  master transfer type
HREADY  out  1  combined ready to master and to all slaves
HRDATA  out  32  muxed read data
HRESP  out  1  muxed response (0 OKAY, 1 ERROR)
HSEL_S  out  NUM_SLAVES  address-phase one-hot selects
HREADYOUT_S  in  NUM_SLAVES  per-slave ready
HRESP_S  in  NUM_SLAVES  per-slave response
HRDATA_S  in  NUM_SLAVES*32  per-slave read data, slave i at [i*32 +: 32]
TIMEOUT_IRQ  out  1  timeout pulse; tied 0 when the feature is compiled out

Behaviour:
- Decode (combinational):
  - HSEL_S[i] = tag match for slave i.
  - Multiple matches resolve to the lowest index only.
  - HSEL_S is driven regardless of HTRANS; slaves qualify it with HTRANS and HREADY.
- Data-phase capture: on an edge with HREADY=1:
  - sel_q <= HSEL_S if HTRANS[1]=1 (NONSEQ/SEQ), else all-zero.
  - dflt_q <= HTRANS[1] & ~|HSEL_S.
  - With HREADY=0, sel_q and dflt_q hold.
- Output mux:
  - sel_q one-hot: HREADY = HREADYOUT_S[k], HRESP = HRESP_S[k], HRDATA = HRDATA_S[k].
  - sel_q zero, no default-slave activity: HREADY=1, HRESP=0, HRDATA=0.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE -> DS_ERR1 when an unmapped NONSEQ/SEQ is captured (HREADY=1 edge).
  - DS_ERR1: HREADY=0, HRESP=1, HRDATA=0; next DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=1, HRDATA=0; next DS_ERR1 if another unmapped active transfer is captured on this edge, else DS_IDLE.
  - An IDLE/BUSY address phase during DS_ERR2 is accepted normally.
- Latency: zero added cycles for mapped slaves; mux is purely combinational from sel_q.
- Back-to-back transfers: the address phase of transfer N+1 overlaps the data phase of N; the select switches exactly on the edge where HREADY=1.
- Slave ERROR: a two-cycle ERROR from a slave passes through unmodified.
- Reset (asynchronous, at any point including mid-wait or in DS_ERR1):
  - sel_q=0, dflt_q=0, FSM=DS_IDLE, timeout counter=0.
  - Outputs immediately: HREADY=1, HRESP=0, HRDATA=0, TIMEOUT_IRQ=0.
  - HSEL_S still follows HADDR.

Optional Feature:
Macro AHB_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each cycle that sel_q is non-zero and the selected HREADYOUT_S is 0, saturating at 255.
  - The counter clears on any HREADY=1 cycle.
  - When it reaches TIMEOUT_CYCLES, the interconnect overrides the slave and issues the DS_ERR1/DS_ERR2 ERROR sequence.
  - sel_q clears at DS_ERR2 completion, and TIMEOUT_IRQ pulses high for 1 cycle during DS_ERR1.
  - The late HREADYOUT_S from the abandoned slave is ignored.
- Undefined: no counter; TIMEOUT_IRQ is constant 0; a slave may stall indefinitely.

Test Plan:
1. Read 0x2000_0010 (slave 1), HREADYOUT_S[1]=0 for 2 cycles, HRDATA_S slave 1=0xDEADBEEF -> HSEL_S=6'b000010 in the address phase; HREADY low 2 cycles then high with HRDATA=0xDEADBEEF, HRESP=0.
2. NONSEQ to 0x3000_0000 (unmapped) -> HSEL_S=0; next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, HRDATA=0, then idle OKAY.
3. Pipelined NONSEQ 0x0000_0004 then 0x4000_0000, slaves return 0x11111111/0x22222222 with zero waits -> HRDATA shows 0x11111111 then 0x22222222 on consecutive cycles.
4. Overlapping tags (SLV_TAGS slaves 2 and 4 both 8'h40), access 0x4000_0000 -> only HSEL_S[2]=1; data comes from slave 2.
5. Assert HRESET during the 3rd wait cycle of slave 3 -> HREADY=1, HRESP=0, HRDATA=0 with no clock edge; after release an IDLE completes OKAY.
6. AHB_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave 3 holds HREADYOUT_S[3]=0 -> after 16 wait cycles HREADY=0/HRESP=1 plus a 1-cycle TIMEOUT_IRQ pulse, then HREADY=1/HRESP=1; a subsequent slave 0 access is OKAY.

Source files
------------

// File: rtl/ahb_lite_interconnect_n.sv
// AHB-lite single-master interconnect: decode, data-phase mux, default slave.
// Define AHB_BUS_TIMEOUT_EN to add the wait-state timeout watchdog.
module ahb_lite_interconnect_n #(
  parameter int unsigned NUM_SLAVES = 6,
  parameter int unsigned DEC_HI = 31,
  parameter int unsigned DEC_LO = 24,
  parameter logic [NUM_SLAVES*8-1:0] SLV_TAGS =
    {8'h60, 8'h50, 8'h48, 8'h40, 8'h20, 8'h00},
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic                     HREADY,
  output logic [31:0]              HRDATA,
  output logic                     HRESP,
  output logic [NUM_SLAVES-1:0]    HSEL_S,
  input  logic [NUM_SLAVES-1:0]    HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]    HRESP_S,
  input  logic [NUM_SLAVES*32-1:0] HRDATA_S,
  output logic                     TIMEOUT_IRQ
);

  localparam int unsigned DW = DEC_HI - DEC_LO + 1;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_e;

  ds_e                   ds_q, ds_d;
  logic [NUM_SLAVES-1:0] hsel;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  dflt_q, dflt_d;
  logic [DW-1:0]         field;
  logic                  rdy_mux;
  logic                  rsp_mux;
  logic [31:0]           rd_mux;
  logic                  active;
  logic                  tmo;
  logic                  unused_in;

  assign field     = HADDR[DEC_HI:DEC_LO];
  assign active    = HTRANS[1];
  assign unused_in = ^{HADDR, HTRANS[0]};

  // Walk downwards so the lowest matching index wins.
  always_comb begin
    hsel = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (field == SLV_TAGS[i*8 +: DW]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
      end
    end
  end

  assign HSEL_S = hsel;

  always_comb begin
    rdy_mux = 1'b0;
    rsp_mux = 1'b0;
    rd_mux  = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel_q[i]) begin
        rdy_mux = rdy_mux | HREADYOUT_S[i];
        rsp_mux = rsp_mux | HRESP_S[i];
        rd_mux  = rd_mux | HRDATA_S[i*32 +: 32];
      end
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    unique case (ds_q)
      DS_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      DS_ERR2: HRESP = 1'b1;
      default: begin
        if (|sel_q) begin
          HREADY = rdy_mux;
          HRESP  = rsp_mux;
          HRDATA = rd_mux;
        end
      end
    endcase
  end

  always_comb begin
    sel_d  = sel_q;
    dflt_d = dflt_q;
    ds_d   = ds_q;
    if (HREADY) begin
      sel_d  = active ? hsel : '0;
      dflt_d = active & ~|hsel;
    end
    unique case (ds_q)
      DS_IDLE: begin
        if ((HREADY && dflt_d) || tmo) ds_d = DS_ERR1;
      end
      DS_ERR1: ds_d = DS_ERR2;
      DS_ERR2: ds_d = dflt_d ? DS_ERR1 : DS_IDLE;
      default: ds_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ds_q   <= DS_IDLE;
      sel_q  <= '0;
      dflt_q <= 1'b0;
    end else begin
      ds_q   <= ds_d;
      sel_q  <= sel_d;
      dflt_q <= dflt_d;
    end
  end

`ifdef AHB_BUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       irq_q, irq_d;
  logic       wait_c;

  always_comb begin
    wait_c = (ds_q == DS_IDLE) && (|sel_q) && !rdy_mux;
    tmo    = wait_c && (({1'b0, cnt_q} + 9'd1) >= 9'(TIMEOUT_CYCLES));
    cnt_d  = cnt_q;
    if (HREADY) cnt_d = '0;
    else if (wait_c && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    irq_d = tmo;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign TIMEOUT_IRQ = irq_q;
`else
  assign tmo         = 1'b0;
  assign TIMEOUT_IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_interconnect_n.sv
// Directed bench for ahb_lite_interconnect_n with overlapping tags 2 and 4.
// Timeout section follows AHB_BUS_TIMEOUT_EN.
module tb_ahb_lite_interconnect_n;

  localparam int NS = 6;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSEQ = 2'b10;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HREADY;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [NS-1:0] HSEL_S;
  logic [NS-1:0] HREADYOUT_S;
  logic [NS-1:0] HRESP_S;
  logic [NS*32-1:0] HRDATA_S;
  logic          TIMEOUT_IRQ;

  int n_tot = 0;
  int n_bad = 0;

  ahb_lite_interconnect_n #(
    .NUM_SLAVES(NS),
    .DEC_HI(31),
    .DEC_LO(24),
    .SLV_TAGS({8'h60, 8'h40, 8'h48, 8'h40, 8'h20, 8'h00}),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .HADDR(HADDR),
    .HTRANS(HTRANS),
    .HREADY(HREADY),
    .HRDATA(HRDATA),
    .HRESP(HRESP),
    .HSEL_S(HSEL_S),
    .HREADYOUT_S(HREADYOUT_S),
    .HRESP_S(HRESP_S),
    .HRDATA_S(HRDATA_S),
    .TIMEOUT_IRQ(TIMEOUT_IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #2;
  endtask

  task automatic set_rd(input int i, input logic [31:0] v);
    HRDATA_S[i*32 +: 32] = v;
  endtask

  task automatic bus(input logic r, input logic p, input logic [31:0] d,
                     input string tag);
    chk({tag, "_rdy"}, {31'd0, HREADY}, {31'd0, r});
    chk({tag, "_rsp"}, {31'd0, HRESP}, {31'd0, p});
    chk({tag, "_rd"}, HRDATA, d);
  endtask

  initial begin
    HRESET      = 1'b1;
    HADDR       = 32'h2000_0010;
    HTRANS      = IDLE;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    HRDATA_S    = '0;
    for (int i = 0; i < NS; i++) set_rd(i, 32'hA0A0_0000 + i);
    #1;
    bus(1'b1, 1'b0, 32'h0, "rst");
    chk("rst_hsel", {26'd0, HSEL_S}, 32'h02);
    chk("rst_irq", {31'd0, TIMEOUT_IRQ}, 32'h0);
    cyc();
    cyc();
    HRESET = 1'b0;

    // read slave 1 with two wait states
    cyc();
    HADDR  = 32'h2000_0010;
    HTRANS = NSEQ;
    HREADYOUT_S[1] = 1'b0;
    set_rd(1, 32'hDEAD_BEEF);
    #1;
    chk("t1_hsel", {26'd0, HSEL_S}, 32'h02);
    chk("t1_addr_rdy", {31'd0, HREADY}, 32'h1);
    cyc();
    HTRANS = IDLE;
    HADDR  = 32'h0;
    #1;
    chk("t1_w1", {31'd0, HREADY}, 32'h0);
    cyc();
    #1;
    chk("t1_w2", {31'd0, HREADY}, 32'h0);
    cyc();
    HREADYOUT_S[1] = 1'b1;
    #1;
    bus(1'b1, 1'b0, 32'hDEAD_BEEF, "t1_done");
    cyc();
    #1;
    bus(1'b1, 1'b0, 32'h0, "t1_idle");

    // unmapped access -> default slave error
    HADDR  = 32'h3000_0000;
    HTRANS = NSEQ;
    #1;
    chk("t2_hsel", {26'd0, HSEL_S}, 32'h0);
    cyc();
    HTRANS = IDLE;
    #1;
    bus(1'b0, 1'b1, 32'h0, "t2_err1");
    cyc();
    #1;
    bus(1'b1, 1'b1, 32'h0, "t2_err2");
    cyc();
    #1;
    bus(1'b1, 1'b0, 32'h0, "t2_after");

    // pipelined slave 0 then 0x40 (slave 2 wins over slave 4)
    set_rd(0, 32'h1111_1111);
    set_rd(2, 32'h2222_2222);
    set_rd(4, 32'h4444_4444);
    HADDR  = 32'h0000_0004;
    HTRANS = NSEQ;
    #1;
    chk("t3_hsel0", {26'd0, HSEL_S}, 32'h01);
    cyc();
    HADDR = 32'h4000_0000;
    #1;
    chk("t4_hsel2", {26'd0, HSEL_S}, 32'h04);
    bus(1'b1, 1'b0, 32'h1111_1111, "t3_d0");
    cyc();
    HTRANS = IDLE;
    #1;
    bus(1'b1, 1'b0, 32'h2222_2222, "t3_d1");
    cyc();

    // slave ERROR passes through
    HADDR  = 32'h6000_0000;
    HTRANS = NSEQ;
    HREADYOUT_S[5] = 1'b0;
    HRESP_S[5]     = 1'b1;
    cyc();
    HTRANS = IDLE;
    #1;
    bus(1'b0, 1'b1, 32'hA0A0_0005, "se_1");
    cyc();
    HREADYOUT_S[5] = 1'b1;
    #1;
    chk("se_2_rdy", {31'd0, HREADY}, 32'h1);
    chk("se_2_rsp", {31'd0, HRESP}, 32'h1);
    cyc();
    HRESP_S[5] = 1'b0;
    #1;
    bus(1'b1, 1'b0, 32'h0, "se_after");

    // back-to-back unmapped: second captured during ERR2
    HADDR  = 32'h3000_0000;
    HTRANS = NSEQ;
    cyc();
    #1;
    bus(1'b0, 1'b1, 32'h0, "bb_a1");
    cyc();
    #1;
    bus(1'b1, 1'b1, 32'h0, "bb_a2");
    cyc();
    HTRANS = IDLE;
    #1;
    bus(1'b0, 1'b1, 32'h0, "bb_b1");
    cyc();
    #1;
    bus(1'b1, 1'b1, 32'h0, "bb_b2");
    cyc();
    #1;
    bus(1'b1, 1'b0, 32'h0, "bb_after");

    // reset in third wait cycle of slave 3
    HADDR  = 32'h4800_0000;
    HTRANS = NSEQ;
    HREADYOUT_S[3] = 1'b0;
    #1;
    chk("t5_hsel3", {26'd0, HSEL_S}, 32'h08);
    cyc();
    HTRANS = IDLE;
    #1;
    chk("t5_w1", {31'd0, HREADY}, 32'h0);
    cyc();
    #1;
    chk("t5_w2", {31'd0, HREADY}, 32'h0);
    cyc();
    #1;
    chk("t5_w3", {31'd0, HREADY}, 32'h0);
    HRESET = 1'b1;
    HADDR  = 32'h6000_0000;
    #1;
    bus(1'b1, 1'b0, 32'h0, "t5_rst");
    chk("t5_rst_hsel", {26'd0, HSEL_S}, 32'h20);
    @(negedge HCLK);
    HRESET = 1'b0;
    cyc();
    #1;
    bus(1'b1, 1'b0, 32'h0, "t5_post");
    cyc();
    #1;
    bus(1'b1, 1'b0, 32'h0, "t5_idle");

    // slave 3 stalls indefinitely
    HADDR  = 32'h4800_0000;
    HTRANS = NSEQ;
    cyc();
    HTRANS = IDLE;
`ifdef AHB_BUS_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("to_w%0d", k), {30'd0, HREADY, TIMEOUT_IRQ}, 32'h0);
      cyc();
    end
    HREADYOUT_S[3] = 1'b1;
    #1;
    bus(1'b0, 1'b1, 32'h0, "to_err1");
    chk("to_irq1", {31'd0, TIMEOUT_IRQ}, 32'h1);
    cyc();
    HADDR  = 32'h0000_0000;
    HTRANS = NSEQ;
    #1;
    bus(1'b1, 1'b1, 32'h0, "to_err2");
    chk("to_irq2", {31'd0, TIMEOUT_IRQ}, 32'h0);
    cyc();
    HTRANS = IDLE;
    #1;
    bus(1'b1, 1'b0, 32'h1111_1111, "to_s0");
`else
    for (int k = 0; k < 20; k++) cyc();
    #1;
    chk("st_rdy", {31'd0, HREADY}, 32'h0);
    chk("st_irq", {31'd0, TIMEOUT_IRQ}, 32'h0);
    HREADYOUT_S[3] = 1'b1;
    set_rd(3, 32'h3333_3333);
    #1;
    bus(1'b1, 1'b0, 32'h3333_3333, "st_done");
    cyc();
    #1;
    bus(1'b1, 1'b0, 32'h0, "st_idle");
`endif
    cyc();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
